// File: rtl/beta_anneal_scheduler.sv
// Annealing-schedule controller: steps a signed fixed-point beta toward a ceiling every N sweeps.
// Optional MAC drain gap around beta changes is compiled in with `define BETA_ANNEAL_DRAIN_EN.
module beta_anneal_scheduler #(
   parameter int BETA_W   = 8,
   parameter int SWEEP_W  = 16,
   parameter int STEP_W   = 8,
   parameter int PIPE_LAT = 6
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [BETA_W-1:0] cfg_beta_start,
   input  logic [BETA_W-1:0] cfg_beta_step,
   input  logic [BETA_W-1:0] cfg_beta_max,
   input  logic [SWEEP_W-1:0] cfg_sweeps_per_step,
   input  logic [STEP_W-1:0] cfg_num_steps,
   input  logic              sweep_done,
   output logic [BETA_W-1:0] beta,
   output logic              mac_en,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] step_idx,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, DRAIN, RUN, DONE} state_t;

   localparam logic signed [BETA_W:0]   SUM_MIN  = {2'b11, {(BETA_W-1){1'b0}}};
   localparam logic signed [BETA_W-1:0] BETA_MIN = {1'b1, {(BETA_W-1){1'b0}}};

   state_t                    state_reg;
   logic signed [BETA_W-1:0]  beta_reg;
   logic signed [BETA_W-1:0]  beta_step_reg;
   logic signed [BETA_W-1:0]  beta_max_reg;
   logic [SWEEP_W-1:0]        sweeps_per_step_reg;
   logic [SWEEP_W-1:0]        sweep_cnt_reg;
   logic [STEP_W-1:0]         num_steps_reg;
   logic [STEP_W-1:0]         step_idx_reg;
   logic                      mac_en_reg;
   logic                      busy_reg;
   logic                      done_reg;
   logic                      err_reg;

   logic signed [BETA_W:0]    beta_sum;
   logic signed [BETA_W:0]    beta_max_ext;
   logic signed [BETA_W-1:0]  beta_sat;
   logic [SWEEP_W-1:0]        sweep_cnt_inc;
   logic [STEP_W-1:0]         step_idx_inc;
   logic                      sweep_last;
   logic                      step_last;

`ifdef BETA_ANNEAL_DRAIN_EN
   localparam int DRAIN_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT);
   logic [DRAIN_W-1:0] drain_cnt_reg;
`endif

   // One extra bit of headroom so the step can never wrap before clamping.
   assign beta_sum     = {beta_reg[BETA_W-1], beta_reg} + {beta_step_reg[BETA_W-1], beta_step_reg};
   assign beta_max_ext = {beta_max_reg[BETA_W-1], beta_max_reg};

   always_comb begin
      beta_sat = beta_sum[BETA_W-1:0];
      if (beta_sum > beta_max_ext) begin
         beta_sat = beta_max_reg;
      end else if (beta_sum < SUM_MIN) begin
         beta_sat = BETA_MIN;
      end
   end

   assign sweep_cnt_inc = sweep_cnt_reg + SWEEP_W'(1);
   assign step_idx_inc  = step_idx_reg + STEP_W'(1);
   assign sweep_last    = (sweep_cnt_inc == sweeps_per_step_reg);
   assign step_last     = (step_idx_inc == num_steps_reg);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg           <= IDLE;
         beta_reg            <= '0;
         beta_step_reg       <= '0;
         beta_max_reg        <= '0;
         sweeps_per_step_reg <= '0;
         sweep_cnt_reg       <= '0;
         num_steps_reg       <= '0;
         step_idx_reg        <= '0;
         mac_en_reg          <= 1'b0;
         busy_reg            <= 1'b0;
         done_reg            <= 1'b0;
         err_reg             <= 1'b0;
`ifdef BETA_ANNEAL_DRAIN_EN
         drain_cnt_reg       <= '0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  beta_reg            <= cfg_beta_start;
                  beta_step_reg       <= cfg_beta_step;
                  beta_max_reg        <= cfg_beta_max;
                  sweeps_per_step_reg <= (cfg_sweeps_per_step == '0) ? SWEEP_W'(1) : cfg_sweeps_per_step;
                  num_steps_reg       <= cfg_num_steps;
                  sweep_cnt_reg       <= '0;
                  step_idx_reg        <= '0;
                  // A coincident sweep_done re-flags the error after the clear.
                  err_reg             <= sweep_done;
                  if (cfg_num_steps == '0) begin
                     state_reg  <= DONE;
                     done_reg   <= 1'b1;
                     busy_reg   <= 1'b0;
                     mac_en_reg <= 1'b0;
                  end else begin
                     busy_reg <= 1'b1;
`ifdef BETA_ANNEAL_DRAIN_EN
                     state_reg     <= DRAIN;
                     drain_cnt_reg <= DRAIN_LOAD;
                     mac_en_reg    <= 1'b0;
`else
                     state_reg  <= RUN;
                     mac_en_reg <= 1'b1;
`endif
                  end
               end else if (sweep_done) begin
                  err_reg <= 1'b1;
               end
            end
`ifdef BETA_ANNEAL_DRAIN_EN
            DRAIN: begin
               if (sweep_done) begin
                  err_reg <= 1'b1;
               end
               drain_cnt_reg <= drain_cnt_reg - DRAIN_W'(1);
               if (drain_cnt_reg <= DRAIN_W'(1)) begin
                  state_reg  <= RUN;
                  mac_en_reg <= 1'b1;
               end
            end
`endif
            RUN: begin
               if (sweep_done) begin
                  if (sweep_last) begin
                     sweep_cnt_reg <= '0;
                     step_idx_reg  <= step_idx_inc;
                     if (step_last) begin
                        state_reg  <= DONE;
                        done_reg   <= 1'b1;
                        busy_reg   <= 1'b0;
                        mac_en_reg <= 1'b0;
                     end else begin
                        beta_reg <= beta_sat;
`ifdef BETA_ANNEAL_DRAIN_EN
                        state_reg     <= DRAIN;
                        drain_cnt_reg <= DRAIN_LOAD;
                        mac_en_reg    <= 1'b0;
`endif
                     end
                  end else begin
                     sweep_cnt_reg <= sweep_cnt_inc;
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
               if (sweep_done) begin
                  err_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign beta     = beta_reg;
   assign mac_en   = mac_en_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign step_idx = step_idx_reg;
   assign err      = err_reg;

endmodule

// File: tb/tb_beta_anneal_scheduler.sv
// Scoreboard bench for beta_anneal_scheduler; covers both builds of BETA_ANNEAL_DRAIN_EN.
module tb_beta_anneal_scheduler;

   localparam int BETA_W   = 8;
   localparam int SWEEP_W  = 16;
   localparam int STEP_W   = 8;
   localparam int PIPE_LAT = 6;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [BETA_W-1:0] cfg_beta_start = '0;
   logic [BETA_W-1:0] cfg_beta_step = '0;
   logic [BETA_W-1:0] cfg_beta_max = '0;
   logic [SWEEP_W-1:0] cfg_sweeps_per_step = '0;
   logic [STEP_W-1:0] cfg_num_steps = '0;
   logic              sweep_done = 1'b0;
   logic [BETA_W-1:0] beta;
   logic              mac_en;
   logic              busy;
   logic              done;
   logic [STEP_W-1:0] step_idx;
   logic              err;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] exp_q[$];
   logic exp_err;

   beta_anneal_scheduler #(
      .BETA_W(BETA_W), .SWEEP_W(SWEEP_W), .STEP_W(STEP_W), .PIPE_LAT(PIPE_LAT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .cfg_beta_start(cfg_beta_start), .cfg_beta_step(cfg_beta_step),
      .cfg_beta_max(cfg_beta_max), .cfg_sweeps_per_step(cfg_sweeps_per_step),
      .cfg_num_steps(cfg_num_steps), .sweep_done(sweep_done),
      .beta(beta), .mac_en(mac_en), .busy(busy), .done(done),
      .step_idx(step_idx), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Independent saturating-ramp model in plain integers.
   task automatic build_expect(input logic [7:0] bs, input logic [7:0] st,
                               input logic [7:0] mx, input int n);
      int b;
      int s;
      b = $signed(bs);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back(b[7:0]);
         s = b + int'($signed(st));
         if (s > int'($signed(mx))) s = $signed(mx);
         if (s < -128) s = -128;
         b = s;
      end
   endtask

   task automatic measure_drain(input bit inject, output int lowcnt);
      lowcnt = 0;
      while (mac_en !== 1'b1 && lowcnt < 64) begin
         if (inject && lowcnt == 0) sweep_done = 1'b1;
         tick;
         sweep_done = 1'b0;
         lowcnt++;
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_beta"}, beta, 0);
      check({tag, "_mac_en"}, mac_en, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_step_idx"}, step_idx, 0);
      check({tag, "_err"}, err, 0);
   endtask

   task automatic run_schedule(input logic [7:0] bs, input logic [7:0] st, input logic [7:0] mx,
                               input logic [15:0] sps, input logic [7:0] n,
                               input bit inject, input bit poke_start, input int abort_at);
      int spe;
      int lowcnt;
      logic [7:0] last_b;
      spe = (sps == 0) ? 1 : int'(sps);
      exp_q.delete();
      build_expect(bs, st, mx, int'(n));
      $display("schedule start=%h step=%h max=%h sweeps=%0d steps=%0d inject=%0d abort_at=%0d",
               bs, st, mx, sps, n, inject, abort_at);
      cfg_beta_start = bs;
      cfg_beta_step = st;
      cfg_beta_max = mx;
      cfg_sweeps_per_step = sps;
      cfg_num_steps = n;
      start = 1'b1;
      tick;
      start = 1'b0;
      exp_err = 1'b0;
      last_b = exp_q.pop_front();
      check("busy_after_start", busy, 1);
      check("beta_after_start", beta, last_b);
      check("err_cleared", err, exp_err);
      check("step_idx_start", step_idx, 0);
`ifdef BETA_ANNEAL_DRAIN_EN
      measure_drain(1'b0, lowcnt);
      check("drain_len_start", lowcnt, PIPE_LAT);
`else
      check("mac_en_start", mac_en, 1);
`endif
      for (int k = 0; k < int'(n); k++) begin
         if (k == abort_at) begin
            reset_n = 1'b0;
            tick;
            check_reset_values("abort");
            reset_n = 1'b1;
            exp_q.delete();
            return;
         end
         if (poke_start && k == 0) begin
            cfg_beta_start = 8'h55;
            cfg_beta_step = 8'h01;
            cfg_sweeps_per_step = 16'd5;
            cfg_num_steps = 8'd1;
            start = 1'b1;
            tick;
            start = 1'b0;
            check("start_ignored_beta", beta, last_b);
            check("start_ignored_busy", busy, 1);
         end
         for (int j = 0; j < spe; j++) begin
            sweep_done = 1'b1;
            tick;
            sweep_done = 1'b0;
            if (j < spe - 1) check("step_hold", step_idx, k);
         end
         if (k < int'(n) - 1) begin
            last_b = exp_q.pop_front();
            check("step_idx_step", step_idx, k + 1);
            check("beta_step", beta, last_b);
            check("busy_step", busy, 1);
            check("err_step", err, exp_err);
`ifdef BETA_ANNEAL_DRAIN_EN
            check("mac_en_drop", mac_en, 0);
            measure_drain(inject && k == 0, lowcnt);
            if (inject && k == 0) exp_err = 1'b1;
            check("drain_len_step", lowcnt, PIPE_LAT);
            check("err_after_drain", err, exp_err);
`else
            check("mac_en_no_gap", mac_en, 1);
`endif
         end else begin
            check("done_pulse", done, 1);
            check("busy_done", busy, 0);
            check("mac_en_done", mac_en, 0);
            check("step_idx_done", step_idx, n);
            check("beta_final", beta, last_b);
            check("err_done", err, exp_err);
            tick;
            check("done_single", done, 0);
            check("beta_hold", beta, last_b);
            check("busy_idle", busy, 0);
         end
      end
      check("scoreboard_empty", exp_q.size(), 0);
   endtask

   task automatic run_zero(input logic [7:0] bs, input bit with_sweep);
      int done_cnt;
      int done_at;
      bit busy_seen;
      $display("schedule start=%h steps=0 sweep_with_start=%0d", bs, with_sweep);
      cfg_beta_start = bs;
      cfg_beta_step = 8'h10;
      cfg_beta_max = 8'h7f;
      cfg_sweeps_per_step = 16'd1;
      cfg_num_steps = 8'd0;
      start = 1'b1;
      sweep_done = with_sweep;
      tick;
      start = 1'b0;
      sweep_done = 1'b0;
      done_cnt = 0;
      done_at = 0;
      busy_seen = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at == 0) done_at = c;
         end
         if (busy !== 1'b0) busy_seen = 1'b1;
         if (c < 3) tick;
      end
      check("zero_done_count", done_cnt, 1);
      check("zero_done_by_t2", (done_at >= 1 && done_at <= 2), 1);
      check("zero_busy_never", busy_seen, 0);
      check("zero_beta", beta, bs);
      check("zero_step_idx", step_idx, 0);
      check("zero_err", err, with_sweep);
   endtask

   initial begin
      tick;
      tick;
      check_reset_values("reset");
      reset_n = 1'b1;
      tick;

      run_schedule(8'h10, 8'h08, 8'h30, 16'd2, 8'd4, 1'b0, 1'b0, -1);
      run_schedule(8'h70, 8'h08, 8'h78, 16'd1, 8'd3, 1'b0, 1'b0, -1);
      run_schedule(8'h90, 8'hF0, 8'h40, 16'd1, 8'd3, 1'b0, 1'b0, -1);
      run_schedule(8'h00, 8'h04, 8'h7f, 16'd0, 8'd3, 1'b0, 1'b0, -1);
      run_schedule(8'h10, 8'h10, 8'h7f, 16'd2, 8'd3, 1'b1, 1'b1, -1);

      $display("idle sweep_done pulse");
      sweep_done = 1'b1;
      tick;
      sweep_done = 1'b0;
      check("err_idle_sweep", err, 1);
      tick;
      check("err_sticky", err, 1);

      run_zero(8'h23, 1'b1);
      run_zero(8'h5a, 1'b0);

      run_schedule(8'h10, 8'h08, 8'h30, 16'd2, 8'd4, 1'b0, 1'b0, 2);
      run_schedule(8'h10, 8'h08, 8'h30, 16'd2, 8'd4, 1'b0, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
